// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
package serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/adder4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
module adder4_slice
  import serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_i,
  output logic [SLICE_W-1:0] s,
  output logic               c_o
);

  logic [SLICE_W:0] w_c;

  assign w_c[0] = c_i;

  for (genvar g = 0; g < SLICE_W; g++) begin : g_bit
    assign s[g]     = a[g] ^ b[g] ^ w_c[g];
    assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
  end

  assign c_o = w_c[SLICE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Adds or subtracts two W-bit operands one nibble per clock (LSB first) through a
// single shared 4-bit slice; START/BUSY/DONE handshake, all outputs registered.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_sub,
  input  logic [SLICE_W*NIBBLES-1:0] i_a,
  input  logic [SLICE_W*NIBBLES-1:0] i_b,
  input  logic                       i_c_in,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [SLICE_W*NIBBLES-1:0] o_sum,
  output logic                       o_c_out,
  output logic                       o_ovf
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_s;
  logic               w_co;
  logic               w_last;

  // Slice width is 4, so the nibble base offset is the index shifted left by two.
  assign w_a_nib = r_a[{r_idx, 2'b00} +: SLICE_W];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: SLICE_W];
  assign w_last  = (r_idx == LAST_IDX);

  adder4_slice u_slice (
    .a   (w_a_nib),
    .b   (w_b_nib),
    .c_i (r_carry),
    .s   (w_s),
    .c_o (w_co)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)  w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_FIN);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            // Subtract is A + ~B + 1: invert B once here, fold the +1 into the carry.
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_c_in ^ i_sub;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[{r_idx, 2'b00} +: SLICE_W] <= w_s;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_c_out <= w_co;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_s[SLICE_W-1] != r_a[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sum   = r_sum;
  assign o_c_out = r_c_out;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed cases plus randomized operations.
module tb_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_sub   (sub),
    .i_a     (a),
    .i_b     (b),
    .i_c_in  (c_in),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_c_out (c_out),
    .o_ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, subtraction as A - B - C_IN with borrow.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub, input logic mcin, input int dcyc);
    exp_t   e;
    longint m  = longint'(1) << W;
    longint ua = longint'(ma);
    longint ub = longint'(mb);
    longint lc = mcin ? 64'sd1 : 64'sd0;
    longint sa = ma[W-1] ? ua - m : ua;
    longint sb = mb[W-1] ? ub - m : ub;
    longint r;
    longint s;
    if (!msub) begin
      r      = ua + ub + lc;
      s      = sa + sb + lc;
      e.cout = (r >= m);
    end else begin
      r      = ua - ub - lc;
      s      = sa - sb - lc;
      e.cout = (r >= 0);
    end
    e.sum = W'(r & (m - 1));
    e.ovf = (s > (m / 2 - 1)) || (s < -(m / 2));
    e.cyc = dcyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum",          64'(sum),   64'(e.sum));
        chk("c_out",        64'(c_out), 64'(e.cout));
        chk("ovf",          64'(ovf),   64'(e.ovf));
        chk("done_latency", 64'(cyc),   64'(e.cyc));
        chk("busy_at_done", 64'(busy),  64'd0);
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at the negedge after completion.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tsub, input logic tcin);
    a = ta; b = tb; sub = tsub; c_in = tcin; start = 1'b1;
    @(negedge clk);
    q.push_back(model(ta, tb, tsub, tcin, cyc + NIBBLES));
    chk("busy_after_start", 64'(busy), 64'd1);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
    repeat (NIBBLES + 1) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
    @(negedge clk);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_sum",   64'(sum),   64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    chk("rst_ovf",   64'(ovf),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1);

    // START held through RUN/FIN: second op accepted on the first IDLE edge.
    a = 16'h0001; b = 16'h0001; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    q.push_back(model(16'h0001, 16'h0001, 1'b0, 1'b0, c0 + NIBBLES));
    @(negedge clk);
    a = 16'h00FF;
    q.push_back(model(16'h00FF, 16'h0001, 1'b0, 1'b0, c0 + 2 * NIBBLES + 2));
    repeat (NIBBLES + 1) @(negedge clk);
    chk("held_start_busy", 64'(busy), 64'd1);
    start = 1'b0;
    repeat (NIBBLES + 1) @(negedge clk);

    // Abort with the nibble index at 2.
    a = 16'h1234; b = 16'h4321; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy",  64'(busy),  64'd0);
    chk("abort_done",  64'(done),  64'd0);
    chk("abort_sum",   64'(sum),   64'd0);
    chk("abort_c_out", 64'(c_out), 64'd0);
    chk("abort_ovf",   64'(ovf),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
